clk_div_monitor: RTL and testbench

Measures a divided clock produced elsewhere in the design by sampling it in the `clk_in` domain. It reports high width, low width and period in `clk_in` cycles, and flags whether the period matches an expected divide ratio within a tolerance. It sits on the consumer side of the clock dividers and serves as an on-chip checker for divider outputs (e.g. divide-by-5) in lab builds and simulation.

---
 rtl/clk_div_monitor.sv | 158 +++++++++++++++
 tb/tb_clk_div_monitor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// Measures high width, low width and period of an asynchronous divided clock in clk_in cycles.
// Define CLK_MON_TIMEOUT_EN to abort a measurement and flag `stuck` when a phase reaches TIMEOUT.
module clk_div_monitor #(
  parameter int CNT_W   = 8,
  parameter int EXP_DIV = 5,
  parameter int TOL     = 1,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clk_mon,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period,
  output logic             meas_valid,
  output logic             ratio_ok,
  output logic             stuck
);

  typedef enum logic [1:0] {SEEK, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   EXP_V   = (CNT_W+1)'(EXP_DIV);
  localparam logic [CNT_W:0]   TOL_V   = (CNT_W+1)'(TOL);

  if (TIMEOUT > (2**CNT_W) - 1) begin : g_timeout_range
    $error("clk_div_monitor: TIMEOUT does not fit in CNT_W bits");
  end

  logic             s1, s2, s3;
  logic             rise, fall;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] hcnt, hcnt_nxt;
  logic [CNT_W-1:0] lcnt, lcnt_nxt;
  logic [CNT_W-1:0] hold, hold_nxt;
  logic             latch;
  logic [CNT_W:0]   new_period;
  logic             new_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Synchronizer resets high so a clk_mon already high at release is not seen as a rise.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= clk_mon;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  assign new_period = {1'b0, hold} + {1'b0, lcnt};
  assign new_ok = (new_period >= EXP_V) ? ((new_period - EXP_V) <= TOL_V)
                                        : ((EXP_V - new_period) <= TOL_V);

`ifdef CLK_MON_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT);
  logic stuck_nxt;
`endif

  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    lcnt_nxt  = lcnt;
    hold_nxt  = hold;
    latch     = 1'b0;
`ifdef CLK_MON_TIMEOUT_EN
    stuck_nxt = stuck;
`endif
    case (state)
      SEEK: begin
        if (rise) begin
          hcnt_nxt  = {{(CNT_W-1){1'b0}}, 1'b1};
          state_nxt = HIGH;
`ifdef CLK_MON_TIMEOUT_EN
          stuck_nxt = 1'b0;
`endif
        end
      end
      HIGH: begin
        if (fall) begin
          hold_nxt  = hcnt;
          lcnt_nxt  = {{(CNT_W-1){1'b0}}, 1'b1};
          state_nxt = LOW;
        end else begin
          hcnt_nxt = sat_inc(hcnt);
`ifdef CLK_MON_TIMEOUT_EN
          if (hcnt_nxt >= TO_V) begin
            stuck_nxt = 1'b1;
            state_nxt = SEEK;
          end
`endif
        end
      end
      LOW: begin
        if (rise) begin
          latch     = 1'b1;
          hcnt_nxt  = {{(CNT_W-1){1'b0}}, 1'b1};
          state_nxt = HIGH;
        end else begin
          lcnt_nxt = sat_inc(lcnt);
`ifdef CLK_MON_TIMEOUT_EN
          if (lcnt_nxt >= TO_V) begin
            stuck_nxt = 1'b1;
            state_nxt = SEEK;
          end
`endif
        end
      end
      default: state_nxt = SEEK;
    endcase
  end

  // Measurement outputs only move on the cycle a full period completes.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= SEEK;
      hcnt       <= '0;
      lcnt       <= '0;
      hold       <= '0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      period     <= '0;
      ratio_ok   <= 1'b0;
      meas_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      hcnt       <= hcnt_nxt;
      lcnt       <= lcnt_nxt;
      hold       <= hold_nxt;
      meas_valid <= latch;
      if (latch) begin
        high_cnt <= hold;
        low_cnt  <= lcnt;
        period   <= new_period;
        ratio_ok <= new_ok;
      end
    end
  end

`ifdef CLK_MON_TIMEOUT_EN
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) stuck <= 1'b0;
    else     stuck <= stuck_nxt;
  end
`else
  assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomized scoreboard bench for clk_div_monitor: expected measurements are derived from the
// phase lengths driven onto clk_mon and checked whenever meas_valid pulses.
module tb_clk_div_monitor;

  localparam int CNT_W   = 8;
  localparam int EXP_DIV = 5;
  localparam int TOL     = 1;
  localparam int TIMEOUT = 255;
  localparam int CNT_MAX = (2**CNT_W) - 1;
`ifdef CLK_MON_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk_in = 1'b0;
  logic             rst = 1'b1;
  logic             clk_mon = 1'b0;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W:0]   period;
  logic             meas_valid;
  logic             ratio_ok;
  logic             stuck;

  clk_div_monitor #(
    .CNT_W(CNT_W), .EXP_DIV(EXP_DIV), .TOL(TOL), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_in(clk_in), .rst(rst), .clk_mon(clk_mon),
    .high_cnt(high_cnt), .low_cnt(low_cnt), .period(period),
    .meas_valid(meas_valid), .ratio_ok(ratio_ok), .stuck(stuck)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int h;
    int l;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_level;
  bit   armed;
  int   pend_h;
  int   pend_l;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // A measurement is owed at every rise that closes a full high+low pair begun by a real rise.
  task automatic driveLevel(input bit v, input int n);
    if (v && model_level == 0) begin
      if (armed) exp_q.push_back('{pend_h, pend_l});
      armed = 1'b1;
    end
    model_level = v;
    clk_mon = v;
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
    if (v) pend_h = n;
    else   pend_l = n;
    if (TO_EN && n >= TIMEOUT) armed = 1'b0;
  endtask

  task automatic applyStimulus(input int h, input int l);
    driveLevel(1'b1, h);
    driveLevel(1'b0, l);
  endtask

  task automatic applyReset(input bit level);
    clk_mon = level;
    rst = 1'b1;
    #1;
    checkOutput("rst_high_cnt", 32'(high_cnt), 0);
    checkOutput("rst_low_cnt", 32'(low_cnt), 0);
    checkOutput("rst_period", 32'(period), 0);
    checkOutput("rst_meas_valid", 32'(meas_valid), 0);
    checkOutput("rst_ratio_ok", 32'(ratio_ok), 0);
    checkOutput("rst_stuck", 32'(stuck), 0);
    exp_q.delete();
    armed = 1'b0;
    model_level = 1;
    repeat (3) begin
      @(posedge clk_in);
      #1;
    end
    rst = 1'b0;
  endtask

  always @(negedge clk_in) begin : monitor
    exp_t e;
    int   eh;
    int   el;
    int   ep;
    int   dev;
    if (!rst && meas_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_meas_valid: got high_cnt=%0d low_cnt=%0d, expected no measurement",
                 high_cnt, low_cnt);
      end else begin
        e   = exp_q.pop_front();
        eh  = (e.h > CNT_MAX) ? CNT_MAX : e.h;
        el  = (e.l > CNT_MAX) ? CNT_MAX : e.l;
        ep  = eh + el;
        dev = (ep >= EXP_DIV) ? ep - EXP_DIV : EXP_DIV - ep;
        checkOutput("high_cnt", 32'(high_cnt), eh);
        checkOutput("low_cnt", 32'(low_cnt), el);
        checkOutput("period", 32'(period), ep);
        checkOutput("ratio_ok", 32'(ratio_ok), (dev <= TOL) ? 1 : 0);
        checkOutput("stuck_at_meas", 32'(stuck), 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_level = 1;
    armed = 1'b0;
    pend_h = 0;
    pend_l = 0;
    @(posedge clk_in);
    #1;
    applyReset(1'b0);
    driveLevel(1'b0, 4);

    // Nominal divide-by-5, then /6 switching to /8.
    repeat (6) applyStimulus(2, 3);
    repeat (4) applyStimulus(3, 3);
    repeat (3) applyStimulus(4, 4);

    for (int i = 0; i < 30; i++)
      applyStimulus($urandom_range(1, 12), $urandom_range(1, 12));

    // Reset during a low phase, then a fresh full period is required.
    driveLevel(1'b1, 2);
    driveLevel(1'b0, 4);
    applyReset(1'b0);
    driveLevel(1'b0, 3);
    repeat (3) applyStimulus(2, 3);

    // clk_mon high across reset release, falls after 7 cycles, then /5.
    driveLevel(1'b1, 2);
    driveLevel(1'b0, 4);
    applyReset(1'b1);
    driveLevel(1'b1, 7);
    driveLevel(1'b0, 3);
    repeat (3) applyStimulus(2, 3);

    // Phase far longer than the counters can hold.
    driveLevel(1'b1, 300);
    checkOutput("stuck_long_high", 32'(stuck), 32'(TO_EN));
    driveLevel(1'b0, 3);
    driveLevel(1'b1, 5);
    checkOutput("stuck_after_rise", 32'(stuck), 0);
    driveLevel(1'b0, 3);
    repeat (3) applyStimulus(2, 3);

    for (int i = 0; i < 10; i++)
      applyStimulus($urandom_range(1, 6), $urandom_range(1, 6));

    driveLevel(1'b1, 6);
    repeat (5) begin
      @(posedge clk_in);
      #1;
    end
    checkOutput("queue_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
